// File: rtl/riscv_pkg.sv
// Shared core definitions: memory-interface FSM states and timeout defaults.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } memif_state_t;

  localparam int MEMIF_TIMEOUT_DEF = 255;

  // Wait-counter width able to hold 0..timeout.
  function automatic int memif_cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/memif_wait_timer.sv
// Wait-state counter for an outstanding bus request; expire flags the last
// allowed waiting cycle so the owner can abort the request on that edge.
module memif_wait_timer
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = MEMIF_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam int CW = memif_cnt_w(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  assign expire = en && (cnt == LAST);

  // Stops at LAST, so the counter never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_handshake_if.sv
// Bridges the core's single memory port onto a req/ack bus with variable
// latency; MemStall freezes the controller until the access completes.
module mem_handshake_if
  import riscv_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = MEMIF_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Adr,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              MemRead,
  input  logic              MemWrite,
  output logic [DATA_W-1:0] ReadData,
  output logic              MemStall,
  output logic              MemFault,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_err,
  output memif_state_t      dbg_state
);

  // Bus handshake: bus_req rises with bus_addr/bus_wdata/bus_we and holds
  // them stable until the cycle bus_ack=1 completes the transfer; bus_rdata
  // and bus_err are only looked at in that cycle, and ack outside REQ is ignored.

  memif_state_t state_q, state_d;
  logic         acc;
  logic         expire;

  assign acc       = MemRead | MemWrite;
  assign dbg_state = state_q;

  memif_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (state_q != REQ),
    .en    ((state_q == REQ) && !bus_ack),
    .expire(expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acc) state_d = REQ;
      REQ: begin
        if (bus_ack) begin
          state_d = bus_err ? FAULT : DONE;
        end else if (expire) begin
          state_d = FAULT;
        end
      end
      DONE:    state_d = IDLE;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  // Reset gating keeps the stall low while reset is held, even with acc high.
  assign MemStall = !reset &&
                    (((state_q == IDLE) && acc) || (state_q == REQ) || (state_q == FAULT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      ReadData  <= '0;
      MemFault  <= 1'b0;
    end else begin
      bus_req <= (state_d == REQ);
      if (state_d == FAULT) MemFault <= 1'b1;
      if ((state_q == IDLE) && acc) begin
        bus_addr  <= Adr;
        bus_wdata <= WriteData;
        bus_we    <= MemWrite;
      end
      if ((state_q == REQ) && bus_ack && !bus_err && !bus_we) begin
        ReadData <= bus_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_handshake_if.sv
// Bench for mem_handshake_if: two instances (long and short timeout) share
// stimulus and are checked every cycle against a transaction-level model.
module tb_mem_handshake_if;
  import riscv_pkg::*;

  localparam int TMO_A = 16;
  localparam int TMO_B = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Adr, WriteData, bus_rdata;
  logic        MemRead, MemWrite, bus_ack, bus_err;

  logic [31:0] rd_a, addr_a, wdata_a, rd_b, addr_b, wdata_b;
  logic        stall_a, fault_a, req_a, we_a, stall_b, fault_b, req_b, we_b;
  memif_state_t dbg_a, dbg_b;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  mem_handshake_if #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO_A)) dut_a (
    .clk(clk), .reset(reset), .Adr(Adr), .WriteData(WriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .ReadData(rd_a),
    .MemStall(stall_a), .MemFault(fault_a), .bus_req(req_a), .bus_we(we_a),
    .bus_addr(addr_a), .bus_wdata(wdata_a), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .bus_err(bus_err), .dbg_state(dbg_a)
  );

  mem_handshake_if #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO_B)) dut_b (
    .clk(clk), .reset(reset), .Adr(Adr), .WriteData(WriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .ReadData(rd_b),
    .MemStall(stall_b), .MemFault(fault_b), .bus_req(req_b), .bus_we(we_b),
    .bus_addr(addr_b), .bus_wdata(wdata_b), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .bus_err(bus_err), .dbg_state(dbg_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    bit          busy;    // request outstanding on the bus
    bit          done;    // completion cycle, no new request allowed
    bit          fault;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waited;  // unacknowledged bus cycles so far
  } mdl_t;

  mdl_t m_a, m_b;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.busy = 0; m.done = 0; m.fault = 0; m.we = 0;
    m.addr = '0; m.wdata = '0; m.rdata = '0; m.waited = 0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input int tmo);
    mdl_t n = m;
    if (m.fault) begin
      n = m;
    end else if (m.busy) begin
      if (bus_ack) begin
        n.busy = 0;
        if (bus_err) n.fault = 1;
        else begin
          n.done = 1;
          if (!m.we) n.rdata = bus_rdata;
        end
      end else if (m.waited + 1 >= tmo) begin
        n.busy  = 0;
        n.fault = 1;
      end else begin
        n.waited = m.waited + 1;
      end
    end else if (m.done) begin
      n.done = 0;
    end else if (MemRead || MemWrite) begin
      n.busy = 1; n.waited = 0;
      n.addr = Adr; n.wdata = WriteData; n.we = MemWrite;
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_a = mdl_reset();
      m_b = mdl_reset();
    end else begin
      m_a = mdl_step(m_a, TMO_A);
      m_b = mdl_step(m_b, TMO_B);
    end
  end

  task automatic cmp_inst(input string tag, input mdl_t m, input logic req, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rd, input logic stall, input logic fault);
    logic exp_stall;
    exp_stall = !reset && (m.fault || m.busy || (!m.done && (MemRead || MemWrite)));
    check({tag, "_bus_req"},   req,   m.busy);
    check({tag, "_bus_we"},    we,    m.we);
    check({tag, "_bus_addr"},  addr,  m.addr);
    check({tag, "_bus_wdata"}, wdata, m.wdata);
    check({tag, "_ReadData"},  rd,    m.rdata);
    check({tag, "_MemStall"},  stall, exp_stall);
    check({tag, "_MemFault"},  fault, m.fault);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_inst("a", m_a, req_a, we_a, addr_a, wdata_a, rd_a, stall_a, fault_a);
      cmp_inst("b", m_b, req_b, we_b, addr_b, wdata_b, rd_b, stall_b, fault_b);
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; bus_ack = 1'b0; bus_err = 1'b0;
    repeat (2) step();
    reset = 1'b0;
  endtask

  // One access from the IDLE cycle through the completion cycle; ack is given
  // in REQ cycle number `waits` (0-based). Counts stall and request cycles.
  task automatic run_access(input logic [31:0] adr, input logic [31:0] wd, input logic wr,
                            input int waits, input logic [31:0] rdat, input logic err,
                            output int st_a, output int st_b, output int rq_a, output int rq_b);
    st_a = 0; st_b = 0; rq_a = 0; rq_b = 0;
    Adr = adr; WriteData = wd; MemRead = !wr; MemWrite = wr;
    bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
    #1;
    st_a += int'(stall_a); st_b += int'(stall_b);
    for (int k = 0; k <= waits; k++) begin
      step();
      Adr = $urandom; WriteData = $urandom;
      bus_ack   = (k == waits);
      bus_err   = err && (k == waits);
      bus_rdata = (k == waits) ? rdat : $urandom;
      #1;
      st_a += int'(stall_a); st_b += int'(stall_b);
      rq_a += int'(req_a);   rq_b += int'(req_b);
    end
    step();
    bus_ack = 1'b0; bus_err = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    #1;
    st_a += int'(stall_a); st_b += int'(stall_b);
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int sa, sb, qa, qb, pulses, gap, ones_seen, stl;
    logic prev;
    Adr = '0; WriteData = '0; bus_rdata = '0;
    MemRead = 1'b0; MemWrite = 1'b0; bus_ack = 1'b0; bus_err = 1'b0;
    reset = 1'b0;
    m_a = mdl_reset(); m_b = mdl_reset();
    #1 reset = 1'b1;
    cmp_en = 1'b1;
    do_reset();
    check("rst_bus_req", req_a, 0);
    check("rst_ReadData", rd_a, 0);
    check("rst_MemFault", fault_a, 0);
    check("rst_bus_addr", addr_a, 0);

    // zero-wait read
    run_access(32'h100, 32'h0, 1'b0, 0, 32'hDEADBEEF, 1'b0, sa, sb, qa, qb);
    check("t1_stall_cycles", sa, 2);
    check("t1_req_cycles", qa, 1);
    check("t1_ReadData", rd_a, 32'hDEADBEEF);
    check("t1_bus_we", we_a, 0);
    check("t1_b_stall_cycles", sb, 2);

    // write with five wait states, address scrambled during REQ
    run_access(32'h200, 32'h12345678, 1'b1, 5, 32'hCAFEF00D, 1'b0, sa, sb, qa, qb);
    check("t2_stall_cycles", sa, 7);
    check("t2_req_cycles", qa, 6);
    check("t2_bus_addr", addr_a, 32'h200);
    check("t2_bus_wdata", wdata_a, 32'h12345678);
    check("t2_bus_we", we_a, 1);
    check("t2_ReadData", rd_a, 32'hDEADBEEF);
    check("t2_b_req_cycles", qb, 4);
    check("t2_b_MemFault", fault_b, 1);
    check("t2_b_stall_cycles", sb, 8);
    check("t2_b_state", dbg_b, FAULT);

    // never acknowledged: both instances time out
    do_reset();
    run_access(32'h300, 32'h0, 1'b0, 20, 32'h0, 1'b0, sa, sb, qa, qb);
    check("t3_b_req_cycles", qb, 4);
    check("t3_a_req_cycles", qa, 16);
    check("t3_b_MemFault", fault_b, 1);
    check("t3_b_bus_req", req_b, 0);
    check("t3_b_stall_cycles", sb, 23);
    repeat (3) step();
    check("t3_b_stall_stuck", stall_b, 1);
    check("t3_a_state", dbg_a, FAULT);

    // error response
    do_reset();
    run_access(32'h400, 32'h0, 1'b0, 0, 32'h0BADF00D, 1'b1, sa, sb, qa, qb);
    check("t4_MemFault", fault_a, 1);
    check("t4_ReadData", rd_a, 0);
    check("t4_state", dbg_a, FAULT);
    check("t4_req_cycles", qa, 1);

    // asynchronous reset in the middle of a request
    do_reset();
    Adr = 32'h500; MemRead = 1'b1; bus_ack = 1'b0;
    repeat (3) step();
    #1;
    check("t5_pre_bus_req", req_a, 1);
    reset = 1'b1;
    #1;
    check("t5_bus_req", req_a, 0);
    check("t5_MemStall", stall_a, 0);
    check("t5_MemFault", fault_a, 0);
    check("t5_state", dbg_a, IDLE);
    step();
    MemRead = 1'b0; reset = 1'b0;
    qa = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      qa += int'(req_a);
    end
    check("t5_no_spurious_req", qa, 0);

    // back-to-back reads, acc held through the completion cycle
    do_reset();
    Adr = 32'h600; MemRead = 1'b1;
    pulses = 0; gap = 0; ones_seen = 0; stl = 0; prev = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus_ack = req_a;
      bus_rdata = 32'h1000 + c;
      #1;
      if (req_a && !prev) pulses++;
      if (req_a) ones_seen++;
      else if (ones_seen == 1) gap++;
      stl += int'(stall_a);
      prev = req_a;
      step();
    end
    MemRead = 1'b0; bus_ack = 1'b0;
    check("t6_req_pulses", pulses, 2);
    check("t6_idle_gap_ok", gap >= 1, 1);
    check("t6_stall_cycles", stl, 4);
    check("t6_ReadData", rd_a, 32'h1004);

    // randomized traffic with occasional resets
    do_reset();
    for (int c = 0; c < 500; c++) begin
      MemRead   = ($urandom_range(0, 3) == 0);
      MemWrite  = ($urandom_range(0, 4) == 0);
      Adr       = $urandom;
      WriteData = $urandom;
      bus_rdata = $urandom;
      bus_ack   = ($urandom_range(0, 2) == 0);
      bus_err   = bus_ack && ($urandom_range(0, 15) == 0);
      reset     = ($urandom_range(0, 49) == 0);
      step();
    end
    reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; bus_ack = 1'b0;
    step();
    @(negedge clk);
    #1;
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $fatal(1, "watchdog");
  end

endmodule
